// File: rtl/note_hit_judge.sv
// Judges each drop window's strum/fret chord against the latched bottom-row note and keeps HUD stats.
// Optional macro SCORE_BCD_EN adds a serial double-dabble converter driving score_bcd/bcd_valid.
module note_hit_judge #(
    parameter int SCORE_W     = 16,
    parameter int HIT_POINTS  = 10,
    parameter int STREAK_STEP = 10,
    parameter int MAX_MULT    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_pulse,
    input  logic [4:0]         note_to_play,
    input  logic [4:0]         frets,
    input  logic               strum,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         streak,
    output logic [2:0]         multiplier,
    output logic [7:0]         miss_count,
    output logic               hit_pulse,
    output logic               miss_pulse
`ifdef SCORE_BCD_EN
    ,
    output logic [19:0]        score_bcd,
    output logic               bcd_valid
`endif
);

    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    localparam logic [SCORE_W+7:0] SCORE_MAX = {8'd0, {SCORE_W{1'b1}}};

    state_t             state, win_state, state_d;
    logic [4:0]         target, win_target;
    logic               latch;
    logic               old_miss, strum_hit, strum_miss, any_miss;
    logic [7:0]         level;
    logic [SCORE_W+7:0] score_sum;
    logic [SCORE_W-1:0] score_d;
    logic [7:0]         streak_d, miss_count_d;

    always_comb begin
        level      = streak / 8'(STREAK_STEP);
        multiplier = (level >= 8'(MAX_MULT - 1)) ? 3'(MAX_MULT) : level[2:0] + 3'd1;
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        old_miss   = latch && (state == ARMED);
        win_state  = state;
        win_target = target;
        if (latch) begin
            // The latch cycle opens a new window; a strum in it is judged against the new note.
            win_target = note_to_play;
            win_state  = (note_to_play != 5'd0) ? ARMED : IDLE;
        end

        strum_hit  = 1'b0;
        strum_miss = 1'b0;
        state_d    = win_state;
        if (strum) begin
            if (win_state == ARMED) begin
                strum_hit  = (frets == win_target);
                strum_miss = (frets != win_target);
                state_d    = DONE;
            end else begin
                strum_miss = 1'b1;
            end
        end
        any_miss = old_miss || strum_miss;

        score_sum = {8'd0, score} +
                    (SCORE_W+8)'(HIT_POINTS) * {{(SCORE_W+5){1'b0}}, multiplier};
        score_d   = score;
        if (strum_hit)
            score_d = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

        // A miss clears the streak before a same-cycle hit counts, leaving streak=1.
        streak_d = streak;
        if (any_miss)
            streak_d = 8'd0;
        if (strum_hit && streak_d != 8'hFF)
            streak_d = streak_d + 8'd1;

        miss_count_d = miss_count;
        if (any_miss && miss_count != 8'hFF)
            miss_count_d = miss_count + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch      <= 1'b0;
            state      <= IDLE;
            target     <= 5'd0;
            score      <= '0;
            streak     <= 8'd0;
            miss_count <= 8'd0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            latch      <= shift_pulse;
            state      <= state_d;
            target     <= win_target;
            score      <= score_d;
            streak     <= streak_d;
            miss_count <= miss_count_d;
            hit_pulse  <= strum_hit;
            miss_pulse <= any_miss;
        end
    end

`ifdef SCORE_BCD_EN
    localparam int CNT_W = $clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] bcd_bin;
    logic [19:0]        bcd_acc, bcd_adj, bcd_shifted;
    logic [CNT_W-1:0]   bcd_cnt;

    always_comb begin
        bcd_adj = bcd_acc;
        for (int d = 0; d < 5; d++) begin
            if (bcd_acc[4*d +: 4] >= 4'd5)
                bcd_adj[4*d +: 4] = bcd_acc[4*d +: 4] + 4'd3;
        end
        bcd_shifted = {bcd_adj[18:0], bcd_bin[SCORE_W-1]};
    end

    // Loading on the same edge the score register changes keeps bcd_valid low whenever they differ.
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_bin   <= '0;
            bcd_acc   <= '0;
            bcd_cnt   <= '0;
            score_bcd <= 20'd0;
            bcd_valid <= 1'b1;
        end else if (score_d != score) begin
            bcd_bin   <= score_d;
            bcd_acc   <= '0;
            bcd_cnt   <= CNT_W'(SCORE_W);
            bcd_valid <= 1'b0;
        end else if (bcd_cnt != '0) begin
            bcd_bin <= bcd_bin << 1;
            bcd_acc <= bcd_shifted;
            bcd_cnt <= bcd_cnt - CNT_W'(1);
            if (bcd_cnt == CNT_W'(1)) begin
                score_bcd <= bcd_shifted;
                bcd_valid <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_note_hit_judge.sv
// Scoreboard bench for note_hit_judge: stimulus pushes expected pulse events, a negedge monitor pops and compares.
module tb_note_hit_judge;

    localparam int S_IDLE = 0, S_ARMED = 1, S_DONE = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        shift_pulse;
    logic [4:0]  note_to_play;
    logic [4:0]  frets;
    logic        strum;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;
    logic [7:0]  miss_count;
    logic        hit_pulse;
    logic        miss_pulse;
`ifdef SCORE_BCD_EN
    logic [19:0] score_bcd;
    logic        bcd_valid;
`endif

    note_hit_judge dut (
        .clk          (clk),
        .reset        (reset),
        .shift_pulse  (shift_pulse),
        .note_to_play (note_to_play),
        .frets        (frets),
        .strum        (strum),
        .score        (score),
        .streak       (streak),
        .multiplier   (multiplier),
        .miss_count   (miss_count),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse)
`ifdef SCORE_BCD_EN
        ,
        .score_bcd    (score_bcd),
        .bcd_valid    (bcd_valid)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    typedef struct {
        logic hit;
        logic miss;
        int   score;
        int   streak;
        int   mult;
        int   mc;
        int   cyc;
    } exp_t;

    exp_t q[$];

    // Reference behaviour of the judge, advanced once per driven cycle.
    int         m_state, m_score, m_streak, m_mc;
    logic [4:0] m_target;
    logic       m_latch;

    function automatic int exp_mult(input int s);
        int m;
        m = 1 + s / 10;
        return (m > 4) ? 4 : m;
    endfunction

    task automatic model_reset();
        m_state  = S_IDLE;
        m_score  = 0;
        m_streak = 0;
        m_mc     = 0;
        m_target = 5'd0;
        m_latch  = 1'b0;
    endtask

    task automatic step(input logic sp, input logic [4:0] note, input logic [4:0] fr, input logic st);
        logic old_miss, hit, smiss;
        int   mult;
        exp_t e;
        shift_pulse  = sp;
        note_to_play = note;
        frets        = fr;
        strum        = st;
        old_miss = m_latch && (m_state == S_ARMED);
        if (m_latch) begin
            m_target = note;
            m_state  = (note != 5'd0) ? S_ARMED : S_IDLE;
        end
        hit   = 1'b0;
        smiss = 1'b0;
        if (st) begin
            if (m_state == S_ARMED) begin
                if (fr == m_target) hit = 1'b1;
                else                smiss = 1'b1;
                m_state = S_DONE;
            end else begin
                smiss = 1'b1;
            end
        end
        mult = exp_mult(m_streak);
        if (hit) m_score = (m_score + 10 * mult > 65535) ? 65535 : m_score + 10 * mult;
        if (old_miss || smiss) begin
            m_streak = 0;
            if (m_mc < 255) m_mc++;
        end
        if (hit && m_streak < 255) m_streak++;
        if (hit || old_miss || smiss) begin
            e.hit    = hit;
            e.miss   = old_miss || smiss;
            e.score  = m_score;
            e.streak = m_streak;
            e.mult   = exp_mult(m_streak);
            e.mc     = m_mc;
            e.cyc    = cyc + 1;
            q.push_back(e);
        end
        m_latch = sp;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 5'd0, 1'b0);
    endtask

    // Drop a note and hit it with a strum on the latch cycle.
    task automatic quick_hit(input logic [4:0] note);
        step(1'b1, note, 5'd0, 1'b0);
        step(1'b0, note, note, 1'b1);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        shift_pulse  = 1'b0;
        note_to_play = 5'd0;
        frets        = 5'd0;
        strum        = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc < cyc) begin
            check("pulse_cycle", cyc, q[0].cyc);
            void'(q.pop_front());
        end
        if (hit_pulse || miss_pulse) begin
            if (q.size() == 0) begin
                check("queued_expectations", q.size(), 1);
            end else begin
                e = q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("hit_pulse", int'(hit_pulse), int'(e.hit));
                check("miss_pulse", int'(miss_pulse), int'(e.miss));
                check("score", int'(score), e.score);
                check("streak", int'(streak), e.streak);
                check("multiplier", int'(multiplier), e.mult);
                check("miss_count", int'(miss_count), e.mc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [4:0] NOTES [8] = '{5'b00001, 5'b00010, 5'b00100, 5'b01000,
                                         5'b10000, 5'b00011, 5'b10101, 5'b11111};

    initial begin
        reset        = 1'b1;
        shift_pulse  = 1'b0;
        note_to_play = 5'd0;
        frets        = 5'd0;
        strum        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        check("rst_score", int'(score), 0);
        check("rst_streak", int'(streak), 0);
        check("rst_multiplier", int'(multiplier), 1);
        check("rst_miss_count", int'(miss_count), 0);
        check("rst_pulses", int'({hit_pulse, miss_pulse}), 0);
`ifdef SCORE_BCD_EN
        check("rst_score_bcd", int'(score_bcd), 0);
        check("rst_bcd_valid", int'(bcd_valid), 1);
`endif

        // First hit, strum one cycle after the latch cycle
        step(1'b1, 5'b00001, 5'd0, 1'b0);
        step(1'b0, 5'b00001, 5'd0, 1'b0);
        step(1'b0, 5'b00001, 5'b00001, 1'b1);
        check("t1_hit_pulse", int'(hit_pulse), 1);
        check("t1_score", int'(score), 10);
        check("t1_streak", int'(streak), 1);
        check("t1_multiplier", int'(multiplier), 1);

        // Multiplier steps at streak 10 and 20, caps at 4
        for (int i = 0; i < 9; i++) quick_hit(NOTES[i % 8]);
        check("t2_streak10", int'(streak), 10);
        check("t2_mult_at10", int'(multiplier), 2);
        check("t2_score100", int'(score), 100);
        quick_hit(5'b10010);
        check("t2_score120", int'(score), 120);
`ifdef SCORE_BCD_EN
        check("bcd_busy", int'(bcd_valid), 0);
        for (int i = 0; i < 17 && !bcd_valid; i++) idle();
        check("bcd_valid_rise", int'(bcd_valid), 1);
        check("bcd_value_120", int'(score_bcd), 32'h00120);
`endif
        for (int i = 0; i < 9; i++) quick_hit(NOTES[(i + 3) % 8]);
        check("t2_mult_at20", int'(multiplier), 3);
        for (int i = 0; i < 20; i++) quick_hit(NOTES[(i + 5) % 8]);
        check("t2_streak40", int'(streak), 40);
        check("t2_mult_cap", int'(multiplier), 4);

        // Wrong chord, then an overstrum in the same window
        step(1'b1, 5'b00110, 5'd0, 1'b0);
        step(1'b0, 5'b00110, 5'd0, 1'b0);
        step(1'b0, 5'b00110, 5'b00100, 1'b1);
        check("t3_miss_pulse", int'(miss_pulse), 1);
        check("t3_streak", int'(streak), 0);
        check("t3_miss_count1", int'(miss_count), 1);
        step(1'b0, 5'b00110, 5'd0, 1'b0);
        step(1'b0, 5'b00110, 5'b00110, 1'b1);
        check("t3_miss_count2", int'(miss_count), 2);

        // Unplayed note missed when the next drop latches; an empty row costs nothing
        step(1'b1, 5'b01000, 5'd0, 1'b0);
        step(1'b0, 5'b01000, 5'd0, 1'b0);
        step(1'b0, 5'b01000, 5'd0, 1'b0);
        step(1'b1, 5'b00000, 5'd0, 1'b0);
        step(1'b0, 5'b00000, 5'd0, 1'b0);
        check("t4_miss_count3", int'(miss_count), 3);
        step(1'b1, 5'b00000, 5'd0, 1'b0);
        step(1'b0, 5'b00000, 5'd0, 1'b0);
        step(1'b0, 5'b00000, 5'd0, 1'b0);
        check("t4_empty_no_pulse", int'({hit_pulse, miss_pulse}), 0);
        check("t4_miss_count_hold", int'(miss_count), 3);

        // Back-to-back drops: neither unplayed note is lost
        step(1'b1, 5'b01000, 5'd0, 1'b0);
        step(1'b1, 5'b10000, 5'd0, 1'b0);
        step(1'b0, 5'b10000, 5'd0, 1'b0);
        step(1'b1, 5'b00000, 5'd0, 1'b0);
        step(1'b0, 5'b00000, 5'd0, 1'b0);
        idle();
        check("t4_back_to_back", int'(miss_count), 5);

        // Old-note miss and new-note hit in the same cycle
        step(1'b1, 5'b00010, 5'd0, 1'b0);
        step(1'b0, 5'b00010, 5'd0, 1'b0);
        step(1'b1, 5'b00100, 5'd0, 1'b0);
        step(1'b0, 5'b00100, 5'b00100, 1'b1);
        check("t5_both_pulses", int'({hit_pulse, miss_pulse}), 3);
        check("t5_streak", int'(streak), 1);
        check("t5_miss_count", int'(miss_count), 6);

        // Run the score up to saturation at x4
        while (m_score + 40 <= 65535) quick_hit(NOTES[m_streak % 8]);
        quick_hit(5'b01100);
        check("t5_score_sat", int'(score), 65535);
        check("t5_streak_sat", int'(streak), 255);
        quick_hit(5'b00011);
        check("t5_score_hold", int'(score), 65535);

        // Reset mid-window drops the pending note without a miss
        step(1'b1, 5'b00001, 5'd0, 1'b0);
        step(1'b0, 5'b00001, 5'b00001, 1'b1);
        step(1'b1, 5'b00001, 5'd0, 1'b0);
        step(1'b0, 5'b00001, 5'd0, 1'b0);
        do_reset();
        check("t6_rst_score", int'(score), 0);
        check("t6_rst_miss_count", int'(miss_count), 0);
`ifdef SCORE_BCD_EN
        check("t6_rst_score_bcd", int'(score_bcd), 0);
        check("t6_rst_bcd_valid", int'(bcd_valid), 1);
`endif
        step(1'b1, 5'b00000, 5'd0, 1'b0);
        step(1'b0, 5'b00000, 5'd0, 1'b0);
        idle();
        check("t6_no_miss_after_rst", int'(miss_count), 0);
        check("t6_no_pulse_after_rst", int'({hit_pulse, miss_pulse}), 0);

        repeat (3) idle();
        check("queue_drained", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
